rr_mux: RTL and testbench

RR_MUX -- requirements
Module: rr_mux

---
 rtl/rr_mux_pkg.sv | 24 ++
 rtl/rr_arb.sv | 49 ++++
 rtl/rr_mux.sv | 171 +++++++++++++++++
 tb/tb_rr_mux.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux_pkg
//
// Purpose : Shared constants and helpers for the round-robin packet mux.
//           Holds the default data width and channel count, plus the
//           function that sizes the channel-index fields.
//
// Contents:
//   DEFAULT_WIDTH  - default per-channel data width in bits
//   DEFAULT_NCH    - default number of input channels
//   chanIdxWidth() - bits needed to hold a channel index 0..n-1
// ---------------------------------------------------------------------------
package rr_mux_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_NCH   = 4;

    // Width of a channel index. The mux always has at least two channels,
    // but the floor of one bit keeps the helper safe for any caller.
    function automatic int chanIdxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : rr_mux_pkg

// File: rtl/rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
//
// Purpose : Combinational round-robin arbiter. Grants the first requesting
//           channel at or after the pointer, searching upward and wrapping
//           modulo NCH.
//
// Ports   :
//   i_req      [NCH-1:0]   request vector (one bit per channel)
//   i_ptr      [SELW-1:0]  search start position, always < NCH
//   o_grant    [NCH-1:0]   one-hot grant, zero when no request
//   o_grantIdx [SELW-1:0]  binary index of the granted channel
//   o_any                  at least one request is present
// ---------------------------------------------------------------------------
module rr_arb
    import rr_mux_pkg::*;
#(
    parameter int NCH  = DEFAULT_NCH,
    parameter int SELW = chanIdxWidth(DEFAULT_NCH)
) (
    input  logic [NCH-1:0]  i_req,
    input  logic [SELW-1:0] i_ptr,
    output logic [NCH-1:0]  o_grant,
    output logic [SELW-1:0] o_grantIdx,
    output logic            o_any
);

    // Walk the channels starting at the pointer. The first request seen
    // wins; later matches are ignored through the found flag, which keeps
    // the grant one-hot without a separate priority-encoder stage.
    always_comb begin
        logic found;
        int   idx;
        o_grant    = '0;
        o_grantIdx = '0;
        found      = 1'b0;
        idx        = 0;
        for (int off = 0; off < NCH; off++) begin
            idx = (int'(i_ptr) + off) % NCH;
            if (!found && i_req[idx]) begin
                found        = 1'b1;
                o_grant[idx] = 1'b1;
                o_grantIdx   = SELW'(idx);
            end
        end
        o_any = found;
    end

endmodule : rr_arb

// File: rtl/rr_mux.sv
// ---------------------------------------------------------------------------
// rr_mux
//
// Purpose : Round-robin N:1 stream multiplexer with a single registered
//           output stage. One beat per cycle can be moved from the granted
//           input channel into the output register, including the cycle in
//           which the current output beat is handed downstream.
//
// Optional feature (macro RR_MUX_LOCK_EN):
//   When defined, a beat with in_last=0 locks arbitration onto its channel
//   until that channel's in_last=1 beat is loaded, so packets are never
//   interleaved. When undefined, in_last is only carried to out_last and
//   no lock state exists.
//
// Parameters:
//   WIDTH  data width per channel (1..64)
//   NCH    number of input channels (2..16)
//   SELW   channel index width, derived from NCH
//
// Ports   :
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   [NCH-1:0]        per-channel beat valid
//   in_ready   [NCH-1:0]        per-channel accept, one-hot or zero
//   in_data    [NCH*WIDTH-1:0]  channel i at [i*WIDTH +: WIDTH]
//   in_last    [NCH-1:0]        per-channel end-of-packet marker
//   out_valid                   output register holds a beat
//   out_ready                   downstream accept
//   out_data   [WIDTH-1:0]      data of the held beat
//   out_ch     [SELW-1:0]       source channel of the held beat
//   out_last                    end-of-packet marker of the held beat
// ---------------------------------------------------------------------------
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int NCH   = DEFAULT_NCH,
    localparam int SELW  = chanIdxWidth(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_last
);

    logic             r_outValid;
    logic [WIDTH-1:0] r_outData;
    logic [SELW-1:0]  r_outCh;
    logic             r_outLast;
    logic [SELW-1:0]  r_ptr;

    logic [NCH-1:0]   w_eligible;
    logic [NCH-1:0]   w_grant;
    logic [SELW-1:0]  w_grantIdx;
    logic             w_anyReq;
    logic             w_canLoad;
    logic             w_load;
    logic [WIDTH-1:0] w_selData;
    logic             w_selLast;
    logic             w_ptrAdvance;
    logic [SELW-1:0]  w_ptrNext;

`ifdef RR_MUX_LOCK_EN
    logic             r_locked;
    logic [SELW-1:0]  r_lockCh;

    // While locked, only the owning channel may compete. The arbiter then
    // sees a single request and grants it regardless of the pointer.
    always_comb begin
        w_eligible = in_valid;
        if (r_locked) begin
            w_eligible           = '0;
            w_eligible[r_lockCh] = in_valid[r_lockCh];
        end
    end

    // The pointer only moves once a packet is complete, so the next packet
    // arbitration starts just past the channel that finished.
    assign w_ptrAdvance = w_selLast;

    // Lock is taken on any non-last beat and released on the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked <= 1'b0;
            r_lockCh <= '0;
        end else if (w_load) begin
            r_locked <= !w_selLast;
            r_lockCh <= w_grantIdx;
        end
    end
`else
    assign w_eligible   = in_valid;
    assign w_ptrAdvance = 1'b1;
`endif

    rr_arb #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_arb (
        .i_req      (w_eligible),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_grantIdx (w_grantIdx),
        .o_any      (w_anyReq)
    );

    // The output register can take a new beat when it is empty or when its
    // current beat leaves this cycle; that second case gives back-to-back
    // beats without a bubble. rst_n gates the handshake so nothing is
    // offered to the inputs while reset is held.
    assign w_canLoad = rst_n && (!r_outValid || out_ready);
    assign w_load    = w_canLoad && w_anyReq;
    assign in_ready  = w_canLoad ? w_grant : '0;

    // AND-OR select driven by the one-hot grant avoids a variable-width
    // index multiply on the flattened data bus.
    always_comb begin
        w_selData = '0;
        w_selLast = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant[i]) begin
                w_selData = w_selData | in_data[i*WIDTH +: WIDTH];
                w_selLast = w_selLast | in_last[i];
            end
        end
    end

    // Explicit wrap keeps the pointer below NCH even when NCH is not a
    // power of two.
    assign w_ptrNext = (w_grantIdx == SELW'(NCH - 1)) ? '0 : (w_grantIdx + 1'b1);

    // Output stage: load takes priority; otherwise a completed handoff
    // empties the register. Data fields are left as-is when emptying.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outCh    <= '0;
            r_outLast  <= 1'b0;
        end else if (w_load) begin
            r_outValid <= 1'b1;
            r_outData  <= w_selData;
            r_outCh    <= w_grantIdx;
            r_outLast  <= w_selLast;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the granted channel on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_load && w_ptrAdvance) begin
            r_ptr <= w_ptrNext;
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_ch    = r_outCh;
    assign out_last  = r_outLast;

endmodule : rr_mux

// File: tb/tb_rr_mux.sv
// ---------------------------------------------------------------------------
// tb_rr_mux
//
// Directed testbench for rr_mux with WIDTH=32, NCH=4. Each test drives a
// fixed input pattern and compares the registered outputs and in_ready
// against hand-computed values. Tests that depend on the packet-lock
// feature follow the RR_MUX_LOCK_EN macro.
// ---------------------------------------------------------------------------
module tb_rr_mux;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_last;

    logic [WIDTH-1:0] chData [NCH];

    int compareCount;
    int mismatchCount;

    rr_mux #(
        .WIDTH (WIDTH),
        .NCH   (NCH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the handshake inputs and repack the per-channel data array.
    task automatic applyStimulus(input logic [NCH-1:0] valid, input logic [NCH-1:0] last,
                                 input logic ready);
        in_valid  = valid;
        in_last   = last;
        out_ready = ready;
        for (int i = 0; i < NCH; i++) begin
            in_data[i*WIDTH +: WIDTH] = chData[i];
        end
        #1;
    endtask

    // Advance one rising edge and settle away from it before sampling.
    task automatic tickCycle();
        @(posedge clk);
        #1;
    endtask

    // Check the full output register contents in one call.
    task automatic checkBeat(input string tag, input logic expValid, input logic [SELW-1:0] expCh,
                             input logic [WIDTH-1:0] expData, input logic expLast);
        checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(expValid));
        checkOutput({tag, ".out_ch"},    64'(out_ch),    64'(expCh));
        checkOutput({tag, ".out_data"},  64'(out_data),  64'(expData));
        checkOutput({tag, ".out_last"},  64'(out_last),  64'(expLast));
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        for (int i = 0; i < NCH; i++) begin
            chData[i] = 32'hC0DE_0000 | 32'(i);
        end
        rst_n     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset: outputs cleared and no channel offered a handshake even
        // with every channel requesting.
        tickCycle();
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        tickCycle();
        checkBeat("reset", 1'b0, 2'd0, 32'h0, 1'b0);
        checkOutput("reset.in_ready", 64'(in_ready), 64'h0);

        // Full round robin from ptr=0 with every channel valid and no
        // back-pressure: 0,1,2,3,0 on consecutive cycles.
        rst_n = 1'b1;
        #1;
        checkOutput("rr.in_ready_first", 64'(in_ready), 64'b0001);
        for (int k = 0; k < 5; k++) begin
            tickCycle();
            checkBeat($sformatf("rr%0d", k), 1'b1, SELW'(k % NCH),
                      32'hC0DE_0000 | 32'(k % NCH), 1'b1);
            checkOutput($sformatf("rr%0d.in_ready", k), 64'(in_ready),
                        64'(4'b0001 << ((k + 1) % NCH)));
        end
        applyStimulus(4'b0000, 4'b1111, 1'b1);
        tickCycle();
        checkOutput("rr.drain", 64'(out_valid), 64'h0);

        // Stall: only ch2 valid with 0xDEADBEEF, downstream not ready.
        chData[2] = 32'hDEAD_BEEF;
        applyStimulus(4'b0100, 4'b1111, 1'b0);
        checkOutput("stall.in_ready_pre", 64'(in_ready), 64'b0100);
        tickCycle();
        checkBeat("stall.load", 1'b1, 2'd2, 32'hDEAD_BEEF, 1'b1);
        checkOutput("stall.load.in_ready", 64'(in_ready), 64'h0);
        for (int k = 0; k < 3; k++) begin
            tickCycle();
            checkBeat($sformatf("stall%0d", k), 1'b1, 2'd2, 32'hDEAD_BEEF, 1'b1);
            checkOutput($sformatf("stall%0d.in_ready", k), 64'(in_ready), 64'h0);
        end
        chData[2] = 32'hC0DE_0002;
        applyStimulus(4'b0000, 4'b1111, 1'b1);
        tickCycle();
        checkOutput("stall.drain", 64'(out_valid), 64'h0);

        // Wrap: ptr=3 with ch0 and ch3 requesting grants ch3, then ch0.
        applyStimulus(4'b1001, 4'b1111, 1'b1);
        checkOutput("wrap.in_ready_pre", 64'(in_ready), 64'b1000);
        tickCycle();
        checkBeat("wrap.ch3", 1'b1, 2'd3, 32'hC0DE_0003, 1'b1);
        checkOutput("wrap.in_ready_mid", 64'(in_ready), 64'b0001);
        tickCycle();
        checkBeat("wrap.ch0", 1'b1, 2'd0, 32'hC0DE_0000, 1'b1);
        applyStimulus(4'b0000, 4'b1111, 1'b1);
        tickCycle();
        checkOutput("wrap.drain", 64'(out_valid), 64'h0);

`ifdef RR_MUX_LOCK_EN
        // Packet lock from ptr=1: ch1 sends last=0,0,1 while ch0 and ch2
        // also request; ch2 follows once the packet completes.
        applyStimulus(4'b0111, 4'b0101, 1'b1);
        checkOutput("lock.in_ready_pre", 64'(in_ready), 64'b0010);
        tickCycle();
        checkBeat("lock.b0", 1'b1, 2'd1, 32'hC0DE_0001, 1'b0);
        checkOutput("lock.b0.in_ready", 64'(in_ready), 64'b0010);
        tickCycle();
        checkBeat("lock.b1", 1'b1, 2'd1, 32'hC0DE_0001, 1'b0);
        checkOutput("lock.b1.in_ready", 64'(in_ready), 64'b0010);
        applyStimulus(4'b0111, 4'b0111, 1'b1);
        tickCycle();
        checkBeat("lock.b2", 1'b1, 2'd1, 32'hC0DE_0001, 1'b1);
        checkOutput("lock.b2.in_ready", 64'(in_ready), 64'b0100);
        tickCycle();
        checkBeat("lock.next", 1'b1, 2'd2, 32'hC0DE_0002, 1'b1);
`else
        // Without locking, in_last passes through and does not hold the
        // grant: ch1 (last=0) is followed directly by ch0.
        applyStimulus(4'b0011, 4'b0001, 1'b1);
        checkOutput("last.in_ready_pre", 64'(in_ready), 64'b0010);
        tickCycle();
        checkBeat("last.ch1", 1'b1, 2'd1, 32'hC0DE_0001, 1'b0);
        checkOutput("last.in_ready_mid", 64'(in_ready), 64'b0001);
        tickCycle();
        checkBeat("last.ch0", 1'b1, 2'd0, 32'hC0DE_0000, 1'b1);
`endif
        applyStimulus(4'b0000, 4'b1111, 1'b1);
        tickCycle();
        checkOutput("mid.drain", 64'(out_valid), 64'h0);

        // Reset during a stall discards the held beat immediately; after
        // release nothing is emitted until a new load, which grants ch0.
        applyStimulus(4'b0010, 4'b1111, 1'b0);
        tickCycle();
        tickCycle();
        checkBeat("rststall.held", 1'b1, 2'd1, 32'hC0DE_0001, 1'b1);
        rst_n = 1'b0;
        #1;
        checkBeat("rststall.async", 1'b0, 2'd0, 32'h0, 1'b0);
        checkOutput("rststall.in_ready", 64'(in_ready), 64'h0);
        tickCycle();
        rst_n = 1'b1;
        applyStimulus(4'b0000, 4'b1111, 1'b1);
        tickCycle();
        checkOutput("rststall.idle", 64'(out_valid), 64'h0);
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        checkOutput("rststall.in_ready_post", 64'(in_ready), 64'b0001);
        tickCycle();
        checkBeat("rststall.first", 1'b1, 2'd0, 32'hC0DE_0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule : tb_rr_mux
